// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU issue controller and its register file.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_NREGS  = 8;
  localparam int REG_AW     = $clog2(ALU_NREGS);

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } issue_state_e;

  // Only the arithmetic ops own the carry and overflow flags.
  function automatic logic is_arith(input alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register file: three combinational read ports, one write port,
// r0 hardwired to zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREGS  = ALU_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] raddr_d,
  output logic [DATA_W-1:0] rdata_d
);

  localparam logic [REG_AW-1:0] R0 = {REG_AW{1'b0}};

  // r0 has no storage at all, so it cannot be written by construction.
  logic [DATA_W-1:0] mem [1:NREGS-1];

  // Register storage with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != R0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == R0) ? {DATA_W{1'b0}} : mem[raddr_a];
  assign rdata_b = (raddr_b == R0) ? {DATA_W{1'b0}} : mem[raddr_b];
  assign rdata_d = (raddr_d == R0) ? {DATA_W{1'b0}} : mem[raddr_d];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ALU: one instruction in flight through
// IDLE -> READ -> EXEC -> WB, with register file writeback and NZCV flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int NREGS  = ALU_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c_out,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic              done,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
);

  localparam logic [REG_AW-1:0] R0 = {REG_AW{1'b0}};

  issue_state_e      state;
  alu_op_e           op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic [DATA_W-1:0] res_q;
  logic              c_q;
  logic              v_q;

  logic              wb_we;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  // N and Z are derived locally from the captured result.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_negative ^ alu_zero;

  assign in_ready = (state == IDLE);

  // Single write port: a writeback always beats a concurrent host write.
  always_comb begin
    wb_we    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = R0;
    rf_wdata = {DATA_W{1'b0}};
    if ((state == WB) && (rd_q != R0)) begin
      wb_we = 1'b1;
    end else begin
      wb_we = 1'b0;
    end
    if (wb_we) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = res_q;
    end else begin
      rf_we    = host_we;
      rf_waddr = host_waddr;
      rf_wdata = host_wdata;
    end
  end

  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs1_q),
    .rdata_a (rs1_data),
    .raddr_b (rs2_q),
    .rdata_b (rs2_data),
    .raddr_d (dbg_raddr),
    .rdata_d (dbg_rdata)
  );

  // Issue FSM with operand, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= ALU_ADD;
      rd_q       <= R0;
      rs1_q      <= R0;
      rs2_q      <= R0;
      alu_a      <= {DATA_W{1'b0}};
      alu_b      <= {DATA_W{1'b0}};
      alu_opcode <= 2'b00;
      res_q      <= {DATA_W{1'b0}};
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      done       <= 1'b0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid && in_ready) begin
            op_q  <= alu_op_e'(in_op);
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            state <= READ;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          alu_a      <= rs1_data;
          alu_b      <= rs2_data;
          alu_opcode <= op_q;
          state      <= EXEC;
        end
        EXEC: begin
          res_q <= alu_result;
          c_q   <= alu_c_out;
          v_q   <= alu_overflow;
          done  <= 1'b1;
          state <= WB;
        end
        WB: begin
          done   <= 1'b0;
          flag_n <= res_q[DATA_W-1];
          flag_z <= (res_q == {DATA_W{1'b0}});
          if (is_arith(op_q)) begin
            flag_c <= c_q;
            flag_v <= v_q;
          end else begin
            flag_c <= flag_c;
            flag_v <= flag_v;
          end
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 32-bit ALU attached.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [2:0]  in_rd = 3'd0, in_rs1 = 3'd0, in_rs2 = 3'd0;
  logic        host_we = 1'b0;
  logic [2:0]  host_waddr = 3'd0;
  logic [31:0] host_wdata = 32'd0;
  logic [2:0]  dbg_raddr = 3'd0;
  logic [31:0] dbg_rdata;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_opcode;
  logic        alu_c_out, alu_overflow, alu_negative, alu_zero;
  logic        done, flag_n, flag_z, flag_c, flag_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .host_we(host_we),
    .host_waddr(host_waddr), .host_wdata(host_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_c_out(alu_c_out), .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .done(done),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  // Reference combinational ALU: carry on ADD, borrow (A<B unsigned) on SUB.
  always_comb begin
    alu_result   = 32'd0;
    alu_c_out    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      2'd0: begin
        {alu_c_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      2'd1: begin
        alu_result   = alu_a - alu_b;
        alu_c_out    = (alu_a < alu_b);
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      2'd2: alu_result = alu_a & alu_b;
      2'd3: alu_result = alu_a | alu_b;
      default: alu_result = 32'd0;
    endcase
    alu_negative = alu_result[31];
    alu_zero     = (alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [2:0] addr, output logic [31:0] data);
    dbg_raddr = addr;
    #1;
    data = dbg_rdata;
  endtask

  task automatic host_wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    host_we = 1'b1; host_waddr = addr; host_wdata = data;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Returns at the falling edge inside READ.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, rs1, rs2);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // From READ, records done in READ/EXEC/WB and returns at the falling edge in IDLE.
  task automatic finish_op(output logic [2:0] dh);
    dh[0] = done;
    @(negedge clk); dh[1] = done;
    @(negedge clk); dh[2] = done;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        load;
    logic [31:0] a, b, res;
    logic [3:0]  nzcv;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [31:0] d;
    logic [2:0]  dh;
    logic [11:0] rdy;
    int          accepts;
    logic        done_seen;

    vt[0] = '{op:2'd1, rd:3'd3, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'd5,          b:32'd7,          res:32'hFFFF_FFFE, nzcv:4'b1010};
    vt[1] = '{op:2'd0, rd:3'd4, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'h7FFF_FFFF, b:32'd1,          res:32'h8000_0000, nzcv:4'b1001};
    vt[2] = '{op:2'd0, rd:3'd5, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'hFFFF_FFFF, b:32'd1,          res:32'h0000_0000, nzcv:4'b0110};
    vt[3] = '{op:2'd2, rd:3'd6, rs1:3'd1, rs2:3'd5, load:1'b0, a:32'd0,          b:32'd0,          res:32'h0000_0000, nzcv:4'b0110};
    vt[4] = '{op:2'd3, rd:3'd7, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'h0F0F_0000, b:32'h0000_00F0, res:32'h0F0F_00F0, nzcv:4'b0010};
    vt[5] = '{op:2'd1, rd:3'd3, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'd10,         b:32'd3,          res:32'h0000_0007, nzcv:4'b0000};
    vt[6] = '{op:2'd1, rd:3'd2, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'h8000_0000, b:32'd1,          res:32'h7FFF_FFFF, nzcv:4'b0001};
    vt[7] = '{op:2'd2, rd:3'd1, rs1:3'd1, rs2:3'd2, load:1'b1, a:32'h8000_0001, b:32'hF000_0001, res:32'h8000_0001, nzcv:4'b1001};

    // Reset state
    #1;
    check("ready_in_reset", {31'd0, in_ready}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_alu_b", alu_b, 32'd0);
    check("reset_opcode", {30'd0, alu_opcode}, 32'd0);
    check("reset_flags", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      rd_reg(3'(r), d);
      check($sformatf("reset_r%0d", r), d, 32'd0);
    end

    // Table-driven instructions
    for (int i = 0; i < 8; i++) begin
      if (vt[i].load) begin
        host_wr(vt[i].rs1, vt[i].a);
        host_wr(vt[i].rs2, vt[i].b);
      end
      issue(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2);
      finish_op(dh);
      check($sformatf("v%0d_done_timing", i), {29'd0, dh}, 32'd4);
      rd_reg(vt[i].rd, d);
      check($sformatf("v%0d_result", i), d, vt[i].res);
      check($sformatf("v%0d_nzcv", i), {28'd0, flag_n, flag_z, flag_c, flag_v}, {28'd0, vt[i].nzcv});
    end

    // in_valid held high: one accept per 4 cycles, rd=0 never lands
    host_wr(3'd1, 32'd3);
    host_wr(3'd2, 32'd4);
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_rd = 3'd0; in_rs1 = 3'd1; in_rs2 = 3'd2;
    accepts = 0;
    for (int c = 0; c < 12; c++) begin
      rdy[11-c] = in_ready;
      if (in_ready) accepts++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ready_pattern", {20'd0, rdy}, 32'h0000_0888);
    check("accept_count", accepts, 32'd3);
    rd_reg(3'd0, d);
    check("r0_after_wb", d, 32'd0);
    host_wr(3'd0, 32'h0000_DEAD);
    rd_reg(3'd0, d);
    check("r0_after_host", d, 32'd0);

    // Host write collides with WB to the same register
    host_wr(3'd1, 32'h0000_1000);
    host_wr(3'd2, 32'h0000_0234);
    issue(2'd0, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    @(negedge clk);
    check("collide_in_wb_done", {31'd0, done}, 32'd1);
    host_we = 1'b1; host_waddr = 3'd3; host_wdata = 32'h0000_AAAA;
    @(negedge clk);
    host_we = 1'b0;
    rd_reg(3'd3, d);
    check("collide_wb_wins", d, 32'h0000_1234);

    // Host write to rs1 during READ: operand uses the old value
    host_wr(3'd1, 32'h0000_0010);
    host_wr(3'd2, 32'h0000_0001);
    issue(2'd1, 3'd4, 3'd1, 3'd2);
    host_we = 1'b1; host_waddr = 3'd1; host_wdata = 32'h0000_0100;
    @(negedge clk);
    host_we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd_reg(3'd4, d);
    check("read_no_bypass", d, 32'h0000_000F);
    rd_reg(3'd1, d);
    check("host_wr_in_read", d, 32'h0000_0100);

    // Reset during EXEC abandons the instruction
    host_wr(3'd1, 32'd5);
    host_wr(3'd2, 32'd7);
    issue(2'd1, 3'd3, 3'd1, 3'd2);
    finish_op(dh);
    check("pre_rst_nzcv", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'h0000_000A);
    issue(2'd0, 3'd2, 3'd1, 3'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_exec_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    check("rst_exec_no_done", {31'd0, done_seen}, 32'd0);
    rd_reg(3'd2, d);
    check("rst_exec_r2", d, 32'd0);
    check("rst_exec_flags", {28'd0, flag_n, flag_z, flag_c, flag_v}, 32'd0);
    check("rst_exec_idle", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
